rx_scr_sync_ctrl: RTL and testbench
===================================

RX_SCR_SYNC_CTRL -- requirements
Module: rx_scr_sync_ctrl

Interface
REQ-001 The block SHALL have parameter P_SYNC_WORD, default 32'hBCBC_BCBC: the unscrambled sync ordered-set data value.
REQ-002 The block SHALL have parameter P_SYNC_CHAR, default 4'b1111: the K-flag pattern that accompanies a sync word.
REQ-003 The block SHALL have parameter P_SYNC_PERIOD, default 1024: words from one sync word to the next, sync included (range 2..65535).
REQ-004 The block SHALL have parameter P_LOCK_CNT, default 3: consecutive well-placed sync words needed to lock (range 2..15).
REQ-005 The block SHALL have parameter P_UNLOCK_CNT, default 4: consecutive sync faults needed to drop lock (range 1..15).
REQ-006 Port i_clk, input, 1 bit: the single clock.
REQ-007 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 Port i_link_up, input, 1: the PCS link is up; low forces the block to hunt.
REQ-009 Port i_rx_valid, input, 1: i_rx_data and i_rx_char are valid this cycle.
REQ-010 Port i_rx_data, input, 32: raw scrambled word.
REQ-011 Port i_rx_char, input, 4: K flag per byte.
REQ-012 Port o_data, output, 32: i_rx_data delayed 1 cycle, driven to the descrambler i_scr_data.
REQ-013 Port o_char, output, 4: i_rx_char delayed 1 cycle, driven to the descrambler i_scr_char.
REQ-014 Port o_scr_en, output, 1: descrambler i_en, aligned with o_data; low means pass-through and seed reload.
REQ-015 Port o_valid, output, 1: i_rx_valid delayed 1 cycle.
REQ-016 Port o_locked, output, 1: high while the state is LOCKED.
REQ-017 Port o_lock_lost, output, 1: single-cycle pulse on the LOCKED-to-HUNT transition.
REQ-018 Port o_err_cnt, output, 16: saturating count of sync faults seen while LOCKED.
REQ-019 Port o_state, output, 2: HUNT=0, CHECK=1, LOCKED=2.

Function
REQ-020 A sync word SHALL be a word with i_rx_valid=1, i_rx_data==P_SYNC_WORD and i_rx_char==P_SYNC_CHAR.
REQ-021 All outputs SHALL be registered; o_data, o_char, o_valid and o_scr_en SHALL be 1-cycle delayed from the input word that decides them.
REQ-022 word_cnt (16b) SHALL load 0 on any sync word and increment on every other valid word; a sync word is "expected" when word_cnt==P_SYNC_PERIOD-1.
REQ-023 A non-sync valid word arriving with word_cnt==P_SYNC_PERIOD-1 ("missing sync") SHALL wrap word_cnt to 0.
REQ-024 In HUNT, o_scr_en SHALL be 0 for every word; a sync word SHALL move the block to CHECK with good_cnt=1 and word_cnt=0.
REQ-025 In CHECK, an expected sync word SHALL increment good_cnt; on reaching P_LOCK_CNT the block SHALL enter LOCKED and clear bad_cnt.
REQ-026 In CHECK, a misplaced sync (word_cnt!=P_SYNC_PERIOD-1) or a missing sync SHALL return the block to HUNT with good_cnt=0.
REQ-027 In CHECK and LOCKED, o_scr_en SHALL be 0 for sync words (forcing a descrambler seed reload) and 1 for all other valid words.
REQ-028 In LOCKED, an expected sync word SHALL clear bad_cnt.
REQ-029 In LOCKED, a missing or misplaced sync SHALL increment bad_cnt and o_err_cnt (o_err_cnt saturates at 16'hFFFF).
REQ-030 In LOCKED, a misplaced sync SHALL also realign word_cnt to 0 and drive o_scr_en=0.
REQ-031 When bad_cnt reaches P_UNLOCK_CNT, the block SHALL go to HUNT and pulse o_lock_lost for 1 cycle.
REQ-032 i_rx_valid=0 in CHECK or LOCKED SHALL be treated as a stream break: the block goes to HUNT (o_lock_lost pulses if it was LOCKED), and o_valid=0 and o_scr_en=0 that cycle.
REQ-033 i_link_up=0 SHALL force HUNT next cycle with all counters except o_err_cnt cleared; o_lock_lost pulses if the block was LOCKED.
REQ-034 Priority SHALL be i_rst > i_link_up=0 > i_rx_valid=0 > sync evaluation.
REQ-035 o_locked and o_state SHALL change in the same cycle that the transition takes effect.

Reset
REQ-036 While i_rst=1 at a clock edge, the block SHALL set state=HUNT, word_cnt=good_cnt=bad_cnt=0, o_data=0, o_char=0, o_valid=0, o_scr_en=0, o_locked=0, o_lock_lost=0, o_err_cnt=0.
REQ-037 Reset asserted mid-lock SHALL NOT pulse o_lock_lost.

Verification (all scenarios use P_SYNC_PERIOD=8, P_LOCK_CNT=3, P_UNLOCK_CNT=2)
REQ-038 Scenario: syncs at words 0,8,16 with continuous valid -> o_locked rises 1 cycle after word 16; o_scr_en=0 on each sync word's output cycle and 1 between syncs.
REQ-039 Scenario: syncs at words 0 and 8, then the next sync at word 13 -> state returns to HUNT; o_lock_lost stays 0.
REQ-040 Scenario: locked, then two consecutive missing syncs -> o_err_cnt=2, o_lock_lost pulses once, o_state=0.
REQ-041 Scenario: locked, then one misplaced sync followed by a sync 8 words later -> o_err_cnt=1, still locked, word_cnt realigned to the misplaced sync.
REQ-042 Scenario: locked, then i_rx_valid=0 for 1 cycle -> next cycle o_state=0 and o_lock_lost=1; the following sync restarts CHECK.
REQ-043 Scenario: i_rst for 1 cycle while locked with o_err_cnt=5 -> all outputs zero next cycle and no o_lock_lost pulse.

Source files
------------

// File: rtl/rx_scr_sync_ctrl.sv
// rx_scr_sync_ctrl: hunts for periodic sync words, locks onto them and gates the descrambler
module rx_scr_sync_ctrl #(
  parameter logic [31:0] P_SYNC_WORD   = 32'hBCBC_BCBC,
  parameter logic [3:0]  P_SYNC_CHAR   = 4'b1111,
  parameter int          P_SYNC_PERIOD = 1024,
  parameter int          P_LOCK_CNT    = 3,
  parameter int          P_UNLOCK_CNT  = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_link_up,
  input  logic        i_rx_valid,
  input  logic [31:0] i_rx_data,
  input  logic [3:0]  i_rx_char,
  output logic [31:0] o_data,
  output logic [3:0]  o_char,
  output logic        o_scr_en,
  output logic        o_valid,
  output logic        o_locked,
  output logic        o_lock_lost,
  output logic [15:0] o_err_cnt,
  output logic [1:0]  o_state
);
  localparam logic [1:0]  HUNT     = 2'd0;
  localparam logic [1:0]  CHECK    = 2'd1;
  localparam logic [1:0]  LOCKED   = 2'd2;
  localparam logic [15:0] LAST     = 16'(P_SYNC_PERIOD - 1);
  localparam logic [3:0]  LOCK_N   = 4'(P_LOCK_CNT);
  localparam logic [3:0]  UNLOCK_N = 4'(P_UNLOCK_CNT);
  logic [1:0]  state_q, state_d;
  logic [15:0] word_cnt_q, word_cnt_d, err_cnt_q, err_cnt_d;
  logic [3:0]  good_cnt_q, good_cnt_d, bad_cnt_q, bad_cnt_d;
  logic        scr_en_d, lock_lost_d;
  logic        is_sync, expected, fault;
  assign is_sync  = i_rx_data == P_SYNC_WORD && i_rx_char == P_SYNC_CHAR;
  assign expected = word_cnt_q == LAST;
  // a sync off its slot or a missing sync in its slot are both faults
  assign fault    = is_sync ^ expected;
  assign o_state   = state_q;
  assign o_err_cnt = err_cnt_q;
  // next-state: link loss beats stream break beats sync evaluation
  always_comb begin
    state_d     = state_q;
    word_cnt_d  = word_cnt_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    err_cnt_d   = err_cnt_q;
    scr_en_d    = 1'b0;
    lock_lost_d = 1'b0;
    if (!i_link_up) begin
      state_d     = HUNT;
      word_cnt_d  = '0;
      good_cnt_d  = '0;
      bad_cnt_d   = '0;
      lock_lost_d = state_q == LOCKED;
    end else if (!i_rx_valid) begin
      lock_lost_d = state_q == LOCKED;
      if (state_q != HUNT) begin
        state_d    = HUNT;
        word_cnt_d = '0;
        good_cnt_d = '0;
        bad_cnt_d  = '0;
      end
    end else begin
      word_cnt_d = (is_sync || expected) ? '0 : word_cnt_q + 16'd1;
      scr_en_d   = state_q != HUNT && !is_sync;
      case (state_q)
        HUNT: if (is_sync) begin
          state_d    = CHECK;
          good_cnt_d = 4'd1;
        end
        CHECK: if (fault) begin
          state_d    = HUNT;
          good_cnt_d = '0;
        end else if (is_sync) begin
          good_cnt_d = good_cnt_q + 4'd1;
          if (good_cnt_q + 4'd1 == LOCK_N) begin
            state_d   = LOCKED;
            bad_cnt_d = '0;
          end
        end
        LOCKED: if (fault) begin
          bad_cnt_d = bad_cnt_q + 4'd1;
          err_cnt_d = &err_cnt_q ? err_cnt_q : err_cnt_q + 16'd1;
          if (bad_cnt_q + 4'd1 == UNLOCK_N) begin
            state_d     = HUNT;
            good_cnt_d  = '0;
            bad_cnt_d   = '0;
            lock_lost_d = 1'b1;
          end
        end else if (is_sync) begin
          bad_cnt_d = '0;
        end
        default: state_d = HUNT;
      endcase
    end
  end
  // state, counters and the one-cycle delayed datapath toward the descrambler
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= HUNT;
      word_cnt_q  <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
      err_cnt_q   <= '0;
      o_data      <= '0;
      o_char      <= '0;
      o_valid     <= 1'b0;
      o_scr_en    <= 1'b0;
      o_locked    <= 1'b0;
      o_lock_lost <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_cnt_q  <= word_cnt_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
      err_cnt_q   <= err_cnt_d;
      o_data      <= i_rx_data;
      o_char      <= i_rx_char;
      o_valid     <= i_rx_valid;
      o_scr_en    <= scr_en_d;
      o_locked    <= state_d == LOCKED;
      o_lock_lost <= lock_lost_d;
    end
  end
endmodule

// File: tb/tb_rx_scr_sync_ctrl.sv
// tb_rx_scr_sync_ctrl: directed scenarios plus random traffic against a behavioural sync model
module tb_rx_scr_sync_ctrl;
  localparam logic [31:0] SW = 32'hBCBC_BCBC;
  localparam logic [3:0]  SC = 4'b1111;
  localparam int PER = 8, LOCKN = 3, UNLOCKN = 2;
  logic clk = 1'b0, rst, link_up, rx_valid;
  logic [31:0] rx_data, o_data;
  logic [3:0]  rx_char, o_char;
  logic o_scr_en, o_valid, o_locked, o_lock_lost;
  logic [15:0] o_err_cnt;
  logic [1:0]  o_state;
  int n_run = 0, n_fail = 0, ll_seen = 0;
  int m_state = 0, m_pos = 0, m_good = 0, m_bad = 0, m_err = 0;
  logic [31:0] e_data;
  logic [3:0]  e_char;
  logic e_valid, e_scr, e_ll;
  int base;
  rx_scr_sync_ctrl #(.P_SYNC_WORD(SW), .P_SYNC_CHAR(SC), .P_SYNC_PERIOD(PER),
                     .P_LOCK_CNT(LOCKN), .P_UNLOCK_CNT(UNLOCKN)) dut (
    .i_clk(clk), .i_rst(rst), .i_link_up(link_up), .i_rx_valid(rx_valid),
    .i_rx_data(rx_data), .i_rx_char(rx_char), .o_data(o_data), .o_char(o_char),
    .o_scr_en(o_scr_en), .o_valid(o_valid), .o_locked(o_locked),
    .o_lock_lost(o_lock_lost), .o_err_cnt(o_err_cnt), .o_state(o_state));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask
  // drive one word, advance the model by the sync rules, then compare all outputs
  task automatic step(input bit r, input bit lu, input bit v, input logic [31:0] d, input logic [3:0] c);
    bit s, ex;
    rst = r; link_up = lu; rx_valid = v; rx_data = d; rx_char = c;
    e_ll = 0; e_scr = 0; e_data = d; e_char = c; e_valid = v;
    if (r) begin
      m_state = 0; m_pos = 0; m_good = 0; m_bad = 0; m_err = 0;
      e_data = 0; e_char = 0; e_valid = 0;
    end else if (!lu || !v) begin
      e_ll = (m_state == 2);
      m_state = 0; m_good = 0; m_bad = 0;
    end else begin
      s = (d == SW) && (c == SC);
      ex = (m_pos == PER - 1);
      m_pos = s ? 0 : (m_pos + 1) % PER;
      e_scr = (m_state != 0) && !s;
      if (m_state == 0) begin
        if (s) begin m_state = 1; m_good = 1; end
      end else if (s && ex) begin
        m_good++;
        m_bad = 0;
        if (m_state == 1 && m_good >= LOCKN) m_state = 2;
      end else if (s || ex) begin
        if (m_state == 1) begin
          m_state = 0; m_good = 0;
        end else begin
          m_bad++;
          if (m_err < 65535) m_err++;
          if (m_bad >= UNLOCKN) begin m_state = 0; m_good = 0; m_bad = 0; e_ll = 1; end
        end
      end
    end
    @(posedge clk); #1;
    chk("state", 32'(o_state), 32'(m_state));
    chk("locked", 32'(o_locked), 32'(m_state == 2));
    chk("lock_lost", 32'(o_lock_lost), 32'(e_ll));
    chk("err_cnt", 32'(o_err_cnt), 32'(m_err));
    chk("scr_en", 32'(o_scr_en), 32'(e_scr));
    chk("valid", 32'(o_valid), 32'(e_valid));
    chk("data", o_data, e_data);
    chk("char", 32'(o_char), 32'(e_char));
    if (o_lock_lost) ll_seen++;
  endtask
  task automatic sync_w();
    step(0, 1, 1, SW, SC);
  endtask
  task automatic data_w(input int n);
    logic [31:0] d;
    repeat (n) begin
      d = $urandom();
      if (d == SW) d = ~d;
      step(0, 1, 1, d, 4'($urandom_range(0, 15)));
    end
  endtask
  task automatic idle_w();
    step(0, 1, 0, $urandom(), 4'($urandom_range(0, 15)));
  endtask
  task automatic reset_w();
    step(1, 1, 1, $urandom(), 4'($urandom_range(0, 15)));
  endtask
  task automatic lock_w();
    sync_w(); data_w(7); sync_w(); data_w(7); sync_w();
  endtask
  initial begin
    int r;
    reset_w(); reset_w();
    chk("rst_state", 32'(o_state), 0);
    chk("rst_data", o_data, 0);
    sync_w(); data_w(7); sync_w();
    chk("s38_not_yet", 32'(o_locked), 0);
    chk("s38_scr_sync", 32'(o_scr_en), 0);
    data_w(1);
    chk("s38_scr_between", 32'(o_scr_en), 1);
    data_w(6); sync_w();
    chk("s38_locked", 32'(o_locked), 1);
    base = ll_seen;
    data_w(8); data_w(8);
    chk("s40_err", 32'(o_err_cnt), 2);
    chk("s40_state", 32'(o_state), 0);
    chk("s40_pulses", 32'(ll_seen - base), 1);
    lock_w(); idle_w();
    chk("s42_state", 32'(o_state), 0);
    chk("s42_ll", 32'(o_lock_lost), 1);
    chk("s42_valid", 32'(o_valid), 0);
    sync_w();
    chk("s42_check", 32'(o_state), 1);
    base = ll_seen;
    data_w(7); sync_w(); data_w(4); sync_w();
    chk("s39_state", 32'(o_state), 0);
    chk("s39_pulses", 32'(ll_seen - base), 0);
    reset_w(); lock_w();
    data_w(3); sync_w(); data_w(7); sync_w();
    chk("s41_err", 32'(o_err_cnt), 1);
    chk("s41_locked", 32'(o_locked), 1);
    repeat (4) begin data_w(3); sync_w(); data_w(7); sync_w(); end
    chk("s43_err5", 32'(o_err_cnt), 5);
    reset_w();
    chk("s43_err", 32'(o_err_cnt), 0);
    chk("s43_ll", 32'(o_lock_lost), 0);
    chk("s43_locked", 32'(o_locked), 0);
    lock_w();
    step(0, 0, 1, SW, SC);
    chk("linkdn_ll", 32'(o_lock_lost), 1);
    chk("linkdn_state", 32'(o_state), 0);
    repeat (4000) begin
      r = $urandom_range(0, 999);
      if (r < 3) reset_w();
      else if (r < 13) step(0, 0, $urandom_range(0, 1), $urandom(), 4'($urandom_range(0, 15)));
      else if (r < 33) idle_w();
      else if ((m_pos == PER - 1) ? (r < 900) : (r < 60)) sync_w();
      else if (r < 80) step(0, 1, 1, SW, 4'b0111);
      else data_w(1);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
